// File: rtl/img_pkg.sv
// Shared definitions for the 3x3 window generator slice.
//   DW_DEF    : default pixel width in bits
//   IMG_W_DEF : default padded line width in pixels
//   IMG_H_DEF : default padded frame height in lines
//   state_t   : frame-fill FSM encoding (FILL until two full lines are buffered, then RUN)
package img_pkg;

  localparam int DW_DEF    = 8;
  localparam int IMG_W_DEF = 258;
  localparam int IMG_H_DEF = 34;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/window_gen_3x3_if.sv
// Pixel-in / window-out bundle of the 3x3 window generator.
//   pixelw, wr           : raster pixel stream into the generator
//   pixelr1..pixelr9     : 3x3 window, row-major, top-left first
//   win_vld, frame_done  : window valid and last-window-of-frame pulse
// Modports: master = pixel source / window sink, slave = generator.
interface window_gen_3x3_if
  import img_pkg::*;
#(
  parameter int DW = DW_DEF
);

  logic [DW-1:0] pixelw;
  logic          wr;
  logic [DW-1:0] pixelr1, pixelr2, pixelr3;
  logic [DW-1:0] pixelr4, pixelr5, pixelr6;
  logic [DW-1:0] pixelr7, pixelr8, pixelr9;
  logic          win_vld;
  logic          frame_done;

  modport master (
    output pixelw, wr,
    input  pixelr1, pixelr2, pixelr3, pixelr4, pixelr5, pixelr6,
    input  pixelr7, pixelr8, pixelr9, win_vld, frame_done
  );

  modport slave (
    input  pixelw, wr,
    output pixelr1, pixelr2, pixelr3, pixelr4, pixelr5, pixelr6,
    output pixelr7, pixelr8, pixelr9, win_vld, frame_done
  );

endinterface

// File: rtl/line_buf.sv
// One line of pixel storage: single-clock RAM of DEPTH words.
//   clk   : clock
//   we    : write enable (write happens on the rising edge)
//   addr  : shared read/write column address
//   wdata : word written at addr
//   rdata : word currently stored at addr; during a write cycle this is the
//           pre-write content, so a line can be read out and overwritten in
//           the same cycle.
module line_buf
  import img_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = IMG_W_DEF,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/window_gen_3x3.sv
// 3x3 sliding-window generator over a padded raster stream.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of window_gen_3x3_if (pixelw/wr in, window/win_vld/frame_done out)
// Each accepted pixel (r,c) with r>=2, c>=2 yields the window whose bottom-right
// corner is (r,c), registered one cycle after acceptance. Two line buffers hold
// rows r-1 and r-2; the column history registers hold columns c-1 and c-2.
module window_gen_3x3
  import img_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  window_gen_3x3_if.slave bus
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic          acc_p0;
  logic [CW-1:0] col_p0;
  logic [RW-1:0] row_p0;
  logic          col_last_p0;
  logic          row_last_p0;
  state_t        state_q;
  state_t        state_nxt;
  logic          emit_p0;
  logic          last_px_p0;

  logic [DW-1:0] top_col_p0, mid_col_p0;
  logic [DW-1:0] top_c1_p0, top_c2_p0;
  logic [DW-1:0] mid_c1_p0, mid_c2_p0;
  logic [DW-1:0] bot_c1_p0, bot_c2_p0;

  logic [DW-1:0] win_p1 [9];
  logic          win_vld_p1;
  logic          frame_done_p1;

  assign acc_p0      = bus.wr;
  assign col_last_p0 = (col_p0 == CW'(IMG_W - 1));
  assign row_last_p0 = (row_p0 == RW'(IMG_H - 1));

  // ---- stage p0: pixel acceptance, raster position, line buffers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_p0 <= '0;
      row_p0 <= '0;
    end else if (acc_p0) begin
      if (col_last_p0) begin
        col_p0 <= '0;
        row_p0 <= row_last_p0 ? '0 : row_p0 + RW'(1);
      end else begin
        col_p0 <= col_p0 + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FILL;
    else        state_q <= state_nxt;
  end

  // RUN covers rows 2..IMG_H-1, so any window emitted lies wholly inside one frame.
  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      FILL: if (acc_p0 && row_p0 == RW'(1) && col_last_p0) state_nxt = RUN;
      RUN:  if (acc_p0 && row_last_p0 && col_last_p0)      state_nxt = FILL;
    endcase
  end

  always_comb begin
    emit_p0    = 1'b0;
    last_px_p0 = 1'b0;
    if (state_q == RUN && acc_p0) begin
      emit_p0    = (col_p0 >= CW'(2));
      last_px_p0 = row_last_p0 && col_last_p0;
    end
  end

  // The middle buffer receives the live row; the row it held shifts into the top buffer.
  line_buf #(.DW(DW), .DEPTH(IMG_W)) u_lb_mid (
    .clk   (clk),
    .we    (acc_p0),
    .addr  (col_p0),
    .wdata (bus.pixelw),
    .rdata (mid_col_p0)
  );

  line_buf #(.DW(DW), .DEPTH(IMG_W)) u_lb_top (
    .clk   (clk),
    .we    (acc_p0),
    .addr  (col_p0),
    .wdata (mid_col_p0),
    .rdata (top_col_p0)
  );

  always_ff @(posedge clk) begin
    if (acc_p0) begin
      top_c2_p0 <= top_c1_p0;
      top_c1_p0 <= top_col_p0;
      mid_c2_p0 <= mid_c1_p0;
      mid_c1_p0 <= mid_col_p0;
      bot_c2_p0 <= bot_c1_p0;
      bot_c1_p0 <= bus.pixelw;
    end
  end

  // ---- stage p1: registered window output ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) win_p1[i] <= '0;
      win_vld_p1    <= 1'b0;
      frame_done_p1 <= 1'b0;
    end else begin
      win_vld_p1    <= emit_p0;
      frame_done_p1 <= last_px_p0;
      if (emit_p0) begin
        win_p1[0] <= top_c2_p0;
        win_p1[1] <= top_c1_p0;
        win_p1[2] <= top_col_p0;
        win_p1[3] <= mid_c2_p0;
        win_p1[4] <= mid_c1_p0;
        win_p1[5] <= mid_col_p0;
        win_p1[6] <= bot_c2_p0;
        win_p1[7] <= bot_c1_p0;
        win_p1[8] <= bus.pixelw;
      end else begin
        for (int i = 0; i < 9; i++) win_p1[i] <= '0;
      end
    end
  end

  assign bus.pixelr1    = win_p1[0];
  assign bus.pixelr2    = win_p1[1];
  assign bus.pixelr3    = win_p1[2];
  assign bus.pixelr4    = win_p1[3];
  assign bus.pixelr5    = win_p1[4];
  assign bus.pixelr6    = win_p1[5];
  assign bus.pixelr7    = win_p1[6];
  assign bus.pixelr8    = win_p1[7];
  assign bus.pixelr9    = win_p1[8];
  assign bus.win_vld    = win_vld_p1;
  assign bus.frame_done = frame_done_p1;

endmodule

// File: tb/tb_window_gen_3x3.sv
// Scoreboard bench for window_gen_3x3: the driver pushes the expected window
// (from the ramp formula) for every pixel that completes one; the monitor pops
// and compares whenever win_vld is seen, and checks zeroed outputs otherwise.
module tb_window_gen_3x3;
  import img_pkg::*;

  localparam int W  = 258;
  localparam int H  = 34;
  localparam int DW = 8;

  typedef struct packed {
    logic [71:0] win;
    logic        fd;
    logic [31:0] stamp;
  } exp_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] cyc   = 0;

  window_gen_3x3_if #(.DW(DW)) bus ();

  window_gen_3x3 #(.DW(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          n_win  = 0;
  int          n_fd   = 0;
  logic [71:0] first_win;
  logic [71:0] second_first_win;
  logic [71:0] last_fd_win;
  logic        prev_vld    = 1'b0;
  logic        toggle_mode = 1'b0;

  function automatic logic [7:0] pix(int r, int c);
    return 8'((r * 258 + c) % 256);
  endfunction

  function automatic logic [71:0] exp_win(int r, int c);
    return {pix(r-2, c-2), pix(r-2, c-1), pix(r-2, c),
            pix(r-1, c-2), pix(r-1, c-1), pix(r-1, c),
            pix(r,   c-2), pix(r,   c-1), pix(r,   c)};
  endfunction

  task automatic check_win(string name, logic [71:0] got, logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_int(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  // Drives n pixels of the ramp starting at (0,0); optional idle cycle after each.
  task automatic send_stream(int n, bit toggle);
    for (int k = 0; k < n; k++) begin
      int r;
      int c;
      r = (k / W) % H;
      c = k % W;
      @(negedge clk);
      bus.wr     = 1'b1;
      bus.pixelw = pix(r, c);
      if (r >= 2 && c >= 2)
        sb.push_back('{win: exp_win(r, c), fd: (r == H-1 && c == W-1), stamp: cyc + 1});
      if (toggle) begin
        @(negedge clk);
        bus.wr     = 1'b0;
        bus.pixelw = 8'hA5;
      end
    end
  endtask

  task automatic drain();
    @(negedge clk);
    bus.wr     = 1'b0;
    bus.pixelw = 8'h5A;
    for (int i = 0; i < 8 && sb.size() != 0; i++) @(negedge clk);
    check_int("drain_pending", sb.size(), 0);
    sb.delete();
  endtask

  task automatic clear_stats();
    n_win            = 0;
    n_fd             = 0;
    first_win        = '0;
    second_first_win = '0;
    last_fd_win      = '0;
  endtask

  // Monitor
  initial begin
    exp_t        e;
    logic [71:0] w;
    forever begin
      @(negedge clk);
      w = {bus.pixelr1, bus.pixelr2, bus.pixelr3, bus.pixelr4, bus.pixelr5,
           bus.pixelr6, bus.pixelr7, bus.pixelr8, bus.pixelr9};
      if (bus.win_vld === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_window got %h fd %0b at cycle %0d", w, bus.frame_done, cyc);
        end else begin
          e = sb.pop_front();
          if (w !== e.win || bus.frame_done !== e.fd || cyc !== e.stamp) begin
            errors++;
            $display("FAIL window got %h fd %0b cycle %0d expected %h fd %0b cycle %0d",
                     w, bus.frame_done, cyc, e.win, e.fd, e.stamp);
          end
        end
        if (n_win == 0)    first_win        = w;
        if (n_win == 8192) second_first_win = w;
        n_win++;
        if (bus.frame_done === 1'b1) begin
          n_fd++;
          last_fd_win = w;
        end
        if (toggle_mode) begin
          checks++;
          if (prev_vld) begin
            errors++;
            $display("FAIL consecutive_vld got win_vld on back-to-back cycles at %0d required gap", cyc);
          end
        end
      end else begin
        checks++;
        if (w !== '0 || bus.frame_done !== 1'b0 || bus.win_vld !== 1'b0) begin
          errors++;
          $display("FAIL idle_zero got win %h fd %b vld %b at cycle %0d required all 0",
                   w, bus.frame_done, bus.win_vld, cyc);
        end
      end
      prev_vld = (bus.win_vld === 1'b1);
    end
  end

  // Stimulus
  initial begin
    bus.wr     = 1'b0;
    bus.pixelw = '0;
    clear_stats();

    // Reset and post-reset idle
    repeat (3) @(negedge clk);
    check_win("reset_window", {bus.pixelr1, bus.pixelr2, bus.pixelr3, bus.pixelr4, bus.pixelr5,
                               bus.pixelr6, bus.pixelr7, bus.pixelr8, bus.pixelr9}, 72'h0);
    check_int("reset_vld", int'(bus.win_vld), 0);
    check_int("reset_fd", int'(bus.frame_done), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      bus.pixelw = 8'(i * 7 + 3);
    end
    check_int("idle_windows", n_win, 0);

    // Continuous ramp frame
    clear_stats();
    send_stream(W * H, 1'b0);
    drain();
    check_win("cont_first", first_win, 72'h00_01_02_02_03_04_04_05_06);
    check_win("cont_last_fd", last_fd_win, 72'h3d_3e_3f_3f_40_41_41_42_43);
    check_int("cont_count", n_win, 8192);
    check_int("cont_fd_count", n_fd, 1);

    // Ramp with wr toggling every cycle
    clear_stats();
    toggle_mode = 1'b1;
    send_stream(W * H, 1'b1);
    drain();
    toggle_mode = 1'b0;
    check_win("tog_first", first_win, 72'h00_01_02_02_03_04_04_05_06);
    check_win("tog_last_fd", last_fd_win, 72'h3d_3e_3f_3f_40_41_41_42_43);
    check_int("tog_count", n_win, 8192);
    check_int("tog_fd_count", n_fd, 1);

    // Reset mid-frame while a window is on the outputs
    clear_stats();
    send_stream(1000, 1'b0);
    @(posedge clk);
    #2;
    check_int("pre_reset_vld", int'(bus.win_vld), 1);
    rst_n      = 1'b0;
    bus.wr     = 1'b0;
    #1;
    check_win("midreset_window", {bus.pixelr1, bus.pixelr2, bus.pixelr3, bus.pixelr4, bus.pixelr5,
                                  bus.pixelr6, bus.pixelr7, bus.pixelr8, bus.pixelr9}, 72'h0);
    check_int("midreset_vld", int'(bus.win_vld), 0);
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clear_stats();
    send_stream(W * H, 1'b0);
    drain();
    check_win("rst_first", first_win, 72'h00_01_02_02_03_04_04_05_06);
    check_int("rst_count", n_win, 8192);
    check_int("rst_fd_count", n_fd, 1);

    // Two frames back-to-back
    clear_stats();
    send_stream(2 * W * H, 1'b0);
    drain();
    check_int("b2b_count", n_win, 16384);
    check_int("b2b_fd_count", n_fd, 2);
    check_win("b2b_first1", first_win, 72'h00_01_02_02_03_04_04_05_06);
    check_win("b2b_first2", second_first_win, 72'h00_01_02_02_03_04_04_05_06);
    check_win("b2b_last_fd", last_fd_win, 72'h3d_3e_3f_3f_40_41_41_42_43);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/window_gen_3x3.md
WINDOW_GEN_3X3 -- requirements
Module: window_gen_3x3

Interface
REQ-001 Parameter DW, default 8, pixel width in bits.
REQ-002 Parameter IMG_W, default 258, padded line width in pixels.
REQ-003 Parameter IMG_H, default 34, padded frame height in lines.
REQ-004 clk  input  1  single clock; all logic on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 pixelw  input  DW  incoming padded raster pixel.
REQ-007 wr  input  1  pixelw valid; one pixel is accepted per clk edge with wr=1.
REQ-008 pixelr1..pixelr9  output  DW each  3x3 window, row-major (1..3 top row, 4..6 middle row, 7..9 bottom row; left to right).
REQ-009 win_vld  output  1  pixelr1..9 hold a valid window this cycle.
REQ-010 frame_done  output  1  one-cycle pulse coincident with the last window of a frame.

Function
REQ-011 Column counter (0..IMG_W-1) and row counter (0..IMG_H-1) shall advance only on accepted pixels; column wraps to 0 after IMG_W-1 and increments row; row wraps to 0 after IMG_H-1.
REQ-012 Accepted pixel (r,c) with r>=2 and c>=2 shall produce exactly one window with top-left (r-2,c-2): pixelr1=(r-2,c-2) ... pixelr3=(r-2,c), pixelr4..6=row r-1 cols c-2..c, pixelr7..9=row r cols c-2..c.
REQ-013 Latency: window and win_vld registered, asserted in the cycle after the edge that accepted pixel (r,c).
REQ-014 Windows per frame shall be (IMG_W-2)*(IMG_H-2) (8192 at defaults), emitted in raster order of top-left.
REQ-015 When win_vld=0, pixelr1..9 shall be driven to 0.
REQ-016 Cycles with wr=0 shall hold all counters, line buffers and window registers; win_vld=0 in the following cycle.
REQ-017 FSM states FILL and RUN; FILL->RUN on acceptance of pixel (1,IMG_W-1); RUN->FILL on acceptance of pixel (IMG_H-1,IMG_W-1); no window is emitted in FILL.
REQ-018 frame_done shall assert with the window produced by pixel (IMG_H-1,IMG_W-1); windows shall never combine pixels from two frames.
REQ-019 Back-to-back frames with no idle cycles shall be supported without loss.
REQ-020 Two line buffers of IMG_W x DW shall hold rows r-1 and r-2; read and write of the same column in one cycle shall return the old (pre-write) value.

Reset
REQ-021 On rst_n=0: counters 0, state FILL, pixelr1..9=0, win_vld=0, frame_done=0; line buffer contents need not be cleared.
REQ-022 Reset mid-frame shall discard the partial frame; the first pixel accepted after release is (0,0).

Structure
REQ-023 DW, IMG_W, IMG_H defaults and the FSM state encoding shall live in a shared package img_pkg.
REQ-024 Line storage shall be one sub-module line_buf (single-clock RAM, depth IMG_W, read-before-write), instantiated twice.

Verification
REQ-025 Ramp frame, pixelw=(r*258+c) mod 256, wr=1 continuous -> first win_vld one cycle after the 519th accepted pixel, window 0,1,2,2,3,4,4,5,6.
REQ-026 Same ramp -> last window 61,62,63,63,64,65,65,66,67 with frame_done=1; total win_vld count 8192; frame_done count 1.
REQ-027 Same ramp with wr toggling 1/0 each cycle -> identical window sequence, win_vld never in consecutive cycles.
REQ-028 rst_n pulse low after 1000 accepted pixels -> all outputs 0 within the reset; a fresh ramp then gives the first window after its 519th pixel, window 0,1,2,2,3,4,4,5,6.
REQ-029 Two ramp frames back-to-back -> 16384 windows, two frame_done pulses, frame-2 first window equals frame-1 first window.
REQ-030 Post-reset idle (wr=0 for 100 cycles) -> win_vld=0, frame_done=0, pixelr1..9=0 throughout.
